id_stage: RTL and testbench



---
 rtl/rv_pkg.sv | 57 +++++
 rtl/id_stage_regfile.sv | 42 ++++
 rtl/id_stage.sv | 151 +++++++++++++++
 tb/tb_id_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcodes, ALU operand selects, branch codes,
// immediate formats and the immediate generator.
package rv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [1:0] ALU_A_REG  = 2'd0;
    localparam logic [1:0] ALU_A_PC   = 2'd1;
    localparam logic [1:0] ALU_A_ZERO = 2'd2;

    localparam logic [1:0] ALU_B_REG  = 2'd0;
    localparam logic [1:0] ALU_B_IMM  = 2'd1;
    localparam logic [1:0] ALU_B_FOUR = 2'd2;

    localparam logic [2:0] ALU_ADD     = 3'b000;
    localparam logic [2:0] ALU_SLT     = 3'b010;
    localparam logic [2:0] ALU_SLTU    = 3'b011;
    localparam logic       ALU_ADD_EXT = 1'b0;
    localparam logic       ALU_SUB_EXT = 1'b1;

    localparam logic [2:0] BRANCH_NIL  = 3'b000;
    localparam logic [2:0] BRANCH_JAL  = 3'b001;
    localparam logic [2:0] BRANCH_JALR = 3'b010;
    localparam logic [2:0] BRANCH_BEQ  = 3'b100;
    localparam logic [2:0] BRANCH_BNE  = 3'b101;
    localparam logic [2:0] BRANCH_BLT  = 3'b110;
    localparam logic [2:0] BRANCH_BGE  = 3'b111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   gen_imm = {{20{i[31]}}, i[31:20]};
            IMM_S:   gen_imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   gen_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   gen_imm = {i[31:12], 12'b0};
            IMM_J:   gen_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: gen_imm = '0;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two async read ports, one write port, x0 hardwired
// to zero, write data bypassed to reads in the same cycle.
module regfile #(
    parameter bit RF_RESET_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] rf [0:31];
    logic        wr_en;

    assign wr_en = we && (waddr != 5'd0);

    // Writes that coincide with reset are dropped even when the array is not cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (RF_RESET_ZERO) begin
                for (int i = 0; i < 32; i++) rf[i] <= '0;
            end
        end else if (wr_en) begin
            rf[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = rf[raddr_a];
        if (raddr_a == 5'd0)                   rdata_a = '0;
        else if (wr_en && waddr == raddr_a)    rdata_a = wdata;
        rdata_b = rf[raddr_b];
        if (raddr_b == 5'd0)                   rdata_b = '0;
        else if (wr_en && waddr == raddr_b)    rdata_b = wdata;
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register file, instruction decode into the ID/EX
// control bundle, load-use hazard detection and stall/hold generation.
module id_stage
    import rv_pkg::*;
#(
    parameter bit RF_RESET_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic        valid,
    input  logic        flush,
    input  logic        ex_mem_load,
    input  logic [4:0]  ex_reg_wnum,
    input  logic        wb_wr,
    input  logic [4:0]  wb_wnum,
    input  logic [31:0] wb_data,
    output logic        mem_load,
    output logic        reg_wr,
    output logic        mem_wr,
    output logic [2:0]  mem_opt,
    output logic        mem_signed,
    output logic [4:0]  reg_anum,
    output logic [4:0]  reg_bnum,
    output logic [4:0]  reg_wnum,
    output logic [1:0]  alu_sela,
    output logic [1:0]  alu_selb,
    output logic [2:0]  ALUctr,
    output logic        ALUext,
    output logic [31:0] imm,
    output logic [31:0] pc_out,
    output logic [2:0]  branch,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic        id_ex_stalled,
    output logic        if_id_hold,
    output logic        illegal
);

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    imm_fmt_e   fmt;
    logic       ill, hz;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];

    always_comb begin
        mem_load   = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        mem_opt    = 3'b000;
        mem_signed = 1'b0;
        reg_anum   = 5'd0;
        reg_bnum   = 5'd0;
        alu_sela   = ALU_A_REG;
        alu_selb   = ALU_B_IMM;
        ALUctr     = ALU_ADD;
        ALUext     = ALU_ADD_EXT;
        branch     = BRANCH_NIL;
        fmt        = IMM_NONE;
        ill        = 1'b0;
        case (opcode)
            OP_LUI: begin
                reg_wr = 1'b1; alu_sela = ALU_A_ZERO; fmt = IMM_U;
            end
            OP_AUIPC: begin
                reg_wr = 1'b1; alu_sela = ALU_A_PC; fmt = IMM_U;
            end
            OP_JAL: begin
                reg_wr = 1'b1; alu_sela = ALU_A_PC; alu_selb = ALU_B_FOUR;
                branch = BRANCH_JAL; fmt = IMM_J;
            end
            OP_JALR: begin
                reg_wr = 1'b1; reg_anum = rs1; alu_sela = ALU_A_PC; alu_selb = ALU_B_FOUR;
                branch = BRANCH_JALR; fmt = IMM_I; ill = (f3 != 3'b000);
            end
            OP_BRANCH: begin
                reg_anum = rs1; reg_bnum = rs2; alu_selb = ALU_B_REG; fmt = IMM_B;
                // Equality uses SUB's zero flag; ordering uses bit0 of SLT/SLTU.
                case (f3)
                    3'b000:  begin branch = BRANCH_BEQ; ALUext = ALU_SUB_EXT; end
                    3'b001:  begin branch = BRANCH_BNE; ALUext = ALU_SUB_EXT; end
                    3'b100:  begin branch = BRANCH_BLT; ALUctr = ALU_SLT;  end
                    3'b101:  begin branch = BRANCH_BGE; ALUctr = ALU_SLT;  end
                    3'b110:  begin branch = BRANCH_BLT; ALUctr = ALU_SLTU; end
                    3'b111:  begin branch = BRANCH_BGE; ALUctr = ALU_SLTU; end
                    default: ill = 1'b1;
                endcase
            end
            OP_LOAD: begin
                mem_load = 1'b1; reg_wr = 1'b1; reg_anum = rs1; fmt = IMM_I;
                mem_opt = f3; mem_signed = ~f3[2];
                ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OP_STORE: begin
                mem_wr = 1'b1; reg_anum = rs1; reg_bnum = rs2; fmt = IMM_S;
                mem_opt = f3; ill = f3[2] || (f3 == 3'b011);
            end
            OP_IMM: begin
                reg_wr = 1'b1; reg_anum = rs1; fmt = IMM_I; ALUctr = f3;
                if (f3 == 3'b001) ill = (f7 != 7'b0000000);
                if (f3 == 3'b101) begin
                    ALUext = f7[5];
                    ill    = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                end
            end
            OP_REG: begin
                reg_wr = 1'b1; reg_anum = rs1; reg_bnum = rs2; alu_selb = ALU_B_REG;
                ALUctr = f3; ALUext = f7[5];
                ill = !((f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            default: ill = 1'b1;
        endcase
        // Never let an unrecognised encoding write state downstream.
        if (ill) begin
            mem_load = 1'b0; reg_wr = 1'b0; mem_wr = 1'b0; branch = BRANCH_NIL;
        end
    end

    assign reg_wnum = reg_wr ? rd : 5'd0;
    assign imm      = gen_imm(instr, fmt);
    assign pc_out   = pc;
    assign illegal  = valid && ill;

    assign hz = ex_mem_load && (ex_reg_wnum != 5'd0) &&
                ((ex_reg_wnum == reg_anum) || (ex_reg_wnum == reg_bnum));

    assign id_ex_stalled = rst || hz || flush || !valid || illegal;
    assign if_id_hold    = hz && !flush && !rst;

    regfile #(.RF_RESET_ZERO(RF_RESET_ZERO)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (reg_anum),
        .raddr_b (reg_bnum),
        .rdata_a (rs1_data),
        .rdata_b (rs2_data),
        .we      (wb_wr),
        .waddr   (wb_wnum),
        .wdata   (wb_data)
    );

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: register file, decode, hazard and reset behaviour.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, pc;
    logic        valid, flush, ex_mem_load;
    logic [4:0]  ex_reg_wnum;
    logic        wb_wr;
    logic [4:0]  wb_wnum;
    logic [31:0] wb_data;
    logic        mem_load, reg_wr, mem_wr, mem_signed, ALUext;
    logic [2:0]  mem_opt, ALUctr, branch;
    logic [4:0]  reg_anum, reg_bnum, reg_wnum;
    logic [1:0]  alu_sela, alu_selb;
    logic [31:0] imm, pc_out, rs1_data, rs2_data;
    logic        id_ex_stalled, if_id_hold, illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage #(.RF_RESET_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .instr(instr), .pc(pc), .valid(valid), .flush(flush),
        .ex_mem_load(ex_mem_load), .ex_reg_wnum(ex_reg_wnum),
        .wb_wr(wb_wr), .wb_wnum(wb_wnum), .wb_data(wb_data),
        .mem_load(mem_load), .reg_wr(reg_wr), .mem_wr(mem_wr), .mem_opt(mem_opt),
        .mem_signed(mem_signed), .reg_anum(reg_anum), .reg_bnum(reg_bnum),
        .reg_wnum(reg_wnum), .alu_sela(alu_sela), .alu_selb(alu_selb),
        .ALUctr(ALUctr), .ALUext(ALUext), .imm(imm), .pc_out(pc_out), .branch(branch),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .id_ex_stalled(id_ex_stalled),
        .if_id_hold(if_id_hold), .illegal(illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] r;
        rst = 1'b1; instr = 32'h0000_0013; pc = 32'h0000_1000; valid = 1'b1;
        flush = 1'b0; ex_mem_load = 1'b0; ex_reg_wnum = 5'd0;
        wb_wr = 1'b0; wb_wnum = 5'd0; wb_data = 32'd0;
        tick(); tick();

        // Under reset a would-be hazard must not hold fetch.
        instr = 32'h0020_81B3; ex_mem_load = 1'b1; ex_reg_wnum = 5'd2;
        #1;
        chk("rst_stall", id_ex_stalled, 1);
        chk("rst_hold", if_id_hold, 0);
        tick();
        rst = 1'b0; ex_mem_load = 1'b0; ex_reg_wnum = 5'd0;

        for (int i = 1; i < 32; i++) begin
            r = 5'(i);
            instr = {12'd0, r, 3'b000, 5'd1, 7'b0010011};
            #1;
            chk($sformatf("rst_x%0d", i), rs1_data, 32'h0);
        end

        // Same-cycle bypass, then value held in the array.
        instr = {12'd0, 5'd5, 3'b000, 5'd1, 7'b0010011};
        wb_wr = 1'b1; wb_wnum = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
        chk("bypass_x5", rs1_data, 32'hDEAD_BEEF);
        tick();
        wb_wr = 1'b0;
        #1;
        chk("stored_x5", rs1_data, 32'hDEAD_BEEF);

        // addi x1,x0,5
        instr = 32'h0050_0093;
        #1;
        chk("addi_reg_wr", reg_wr, 1);
        chk("addi_wnum", reg_wnum, 1);
        chk("addi_anum", reg_anum, 0);
        chk("addi_selb", alu_selb, 1);
        chk("addi_imm", imm, 5);
        chk("addi_aluctr", ALUctr, 0);
        chk("addi_stall", id_ex_stalled, 0);
        chk("addi_pc", pc_out, 32'h0000_1000);

        // add x3,x1,x2 behind a load to x2
        instr = 32'h0020_81B3; ex_mem_load = 1'b1; ex_reg_wnum = 5'd2;
        #1;
        chk("hz_stall", id_ex_stalled, 1);
        chk("hz_hold", if_id_hold, 1);
        chk("hz_bnum", reg_bnum, 2);
        chk("hz_selb", alu_selb, 0);
        tick();
        ex_mem_load = 1'b0;
        #1;
        chk("hz_clr_stall", id_ex_stalled, 0);
        chk("hz_clr_hold", if_id_hold, 0);

        ex_mem_load = 1'b1; flush = 1'b1;
        #1;
        chk("hzfl_stall", id_ex_stalled, 1);
        chk("hzfl_hold", if_id_hold, 0);
        ex_mem_load = 1'b0; flush = 1'b0;

        // beq x1,x2,-4
        instr = 32'hFE20_8EE3;
        #1;
        chk("beq_branch", branch, 3'b100);
        chk("beq_aluctr", ALUctr, 0);
        chk("beq_ext", ALUext, 1);
        chk("beq_imm", imm, 32'hFFFF_FFFC);
        chk("beq_reg_wr", reg_wr, 0);
        chk("beq_wnum", reg_wnum, 0);

        // lui x1,0x12345
        instr = 32'h1234_50B7;
        #1;
        chk("lui_imm", imm, 32'h1234_5000);
        chk("lui_sela", alu_sela, 2);
        chk("lui_selb", alu_selb, 1);

        // sw x2,8(x1)
        instr = 32'h0020_A423;
        #1;
        chk("sw_mem_wr", mem_wr, 1);
        chk("sw_reg_wr", reg_wr, 0);
        chk("sw_imm", imm, 8);
        chk("sw_opt", mem_opt, 3'b010);

        // lbu x4,0(x1)
        instr = 32'h0000_C203;
        #1;
        chk("lbu_load", mem_load, 1);
        chk("lbu_signed", mem_signed, 0);
        chk("lbu_opt", mem_opt, 3'b100);
        chk("lbu_wnum", reg_wnum, 4);

        // srai x1,x1,3
        instr = 32'h4030_D093;
        #1;
        chk("srai_aluctr", ALUctr, 3'b101);
        chk("srai_ext", ALUext, 1);

        // Write to x0 is ignored, both bypassed and stored.
        instr = {12'd0, 5'd0, 3'b000, 5'd1, 7'b0010011};
        wb_wr = 1'b1; wb_wnum = 5'd0; wb_data = 32'h0000_1234;
        #1;
        chk("x0_bypass", rs1_data, 0);
        tick();
        wb_wr = 1'b0;
        #1;
        chk("x0_stored", rs1_data, 0);

        instr = 32'h0000_007F;
        #1;
        chk("ill_flag", illegal, 1);
        chk("ill_stall", id_ex_stalled, 1);
        chk("ill_reg_wr", reg_wr, 0);

        instr = 32'h0050_0093; valid = 1'b0;
        #1;
        chk("invalid_stall", id_ex_stalled, 1);
        valid = 1'b1;

        // Reset clears x5 and drops the coinciding write to x6.
        instr = 32'h0062_81B3; rst = 1'b1;
        wb_wr = 1'b1; wb_wnum = 5'd6; wb_data = 32'h0000_00AA;
        tick();
        rst = 1'b0; wb_wr = 1'b0;
        #1;
        chk("rst_clr_x5", rs1_data, 0);
        chk("rst_drop_x6", rs2_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
